bfsk_demodulator: RTL and testbench

- Receive end of the BFSK link. Consumes the 18-bit sign-extended sine sample stream the modulator produces.
- Detects the constant-level sync preamble and then slices fixed-length symbol windows.
- Decides each bit by counting rising zero crossings per window: low tone (increment 655) gives ~4 crossings per 400 samples, high tone (increment 1311) gives ~8.
- Emits one data bit per symbol with a valid strobe.

---
 rtl/bfsk_demodulator.sv | 195 +++++++++++++++++++
 tb/tb_bfsk_demodulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bfsk_demodulator.sv
`default_nettype none
// ============================================================================
// Module      : bfsk_demodulator
// Description : BFSK receiver. Hunts for a constant-level sync preamble,
//               then slices fixed-length symbol windows and decides each bit
//               by counting rising (negative-to-non-negative) zero crossings.
// Ports       : clk          - system clock, rising edge
//               reset_n      - asynchronous active-low reset
//               sample_in    - two's complement sine sample
//               sample_valid - qualifies sample_in
//               data_out     - decided bit, held until the next decision
//               data_valid   - one-cycle strobe for data_out
//               locked       - high in SYNC or DEMOD
//               frame_done   - strobe together with the last bit of a frame
//               carrier_lost - strobe on a crossing-free window (optional)
// Options     : BFSK_DEMOD_CARRIER_CHECK_EN - when defined, a window with no
//               crossings aborts the frame and pulses carrier_lost instead of
//               emitting a 0 bit. When undefined, carrier_lost is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module bfsk_demodulator #(
    parameter int                     SAMPLE_WIDTH = 18,
    parameter logic [SAMPLE_WIDTH-1:0] SYNC_WORD   = 18'h0FFFF,
    parameter int                     SYNC_MIN     = 8,
    parameter int                     SYMBOL_LEN   = 400,
    parameter int                     XING_THRESH  = 6,
    parameter int                     FRAME_BITS   = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic                    data_out,
    output logic                    data_valid,
    output logic                    locked,
    output logic                    frame_done,
    output logic                    carrier_lost
);

    localparam int c_samp_w = $clog2(SYMBOL_LEN + 1);
    localparam int c_xing_w = $clog2(SYMBOL_LEN / 2 + 1);
    localparam int c_bit_w  = $clog2(FRAME_BITS + 1);
    localparam int c_sync_w = $clog2(SYNC_MIN + 1);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_DEMOD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_sync_w-1:0] sync_cnt_q, sync_cnt_d;
    logic [c_samp_w-1:0] samp_cnt_q, samp_cnt_d;
    logic [c_xing_w-1:0] xing_cnt_q, xing_cnt_d;
    logic [c_bit_w-1:0]  bit_cnt_q, bit_cnt_d;
    logic                prev_sign_q, prev_sign_d;
    logic                data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                frame_done_q, frame_done_d;
`ifdef BFSK_DEMOD_CARRIER_CHECK_EN
    logic                carrier_lost_q, carrier_lost_d;
`endif

    logic                w_is_sync;
    logic                w_sign;
    logic [c_xing_w-1:0] w_xing_next;
    logic                take;
    logic                leave;

    assign w_is_sync = (sample_in == SYNC_WORD);
    assign w_sign    = sample_in[SAMPLE_WIDTH-1];

    // Crossing count including the current sample, saturating at all-ones.
    assign w_xing_next = (prev_sign_q && !w_sign && (xing_cnt_q != {c_xing_w{1'b1}}))
                       ? xing_cnt_q + 1'b1 : xing_cnt_q;

    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        xing_cnt_d   = xing_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        prev_sign_d  = prev_sign_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_done_d = 1'b0;
`ifdef BFSK_DEMOD_CARRIER_CHECK_EN
        carrier_lost_d = 1'b0;
`endif
        take  = 1'b0;
        leave = 1'b0;

        if (sample_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (w_is_sync) begin
                        sync_cnt_d = sync_cnt_q + 1'b1;
                        if (sync_cnt_q == c_sync_w'(SYNC_MIN - 1)) begin
                            state_d = ST_SYNC;
                        end
                    end else begin
                        sync_cnt_d = '0;
                    end
                end
                ST_SYNC: begin
                    // Counters and prev_sign are zero here, so the first
                    // data sample goes through the ordinary DEMOD path.
                    if (!w_is_sync) begin
                        state_d = ST_DEMOD;
                        take    = 1'b1;
                    end
                end
                ST_DEMOD: take = 1'b1;
                default:  state_d = ST_HUNT;
            endcase
        end

        if (take) begin
            prev_sign_d = w_sign;
            samp_cnt_d  = samp_cnt_q + 1'b1;
            xing_cnt_d  = w_xing_next;
            if (samp_cnt_q == c_samp_w'(SYMBOL_LEN - 1)) begin
                samp_cnt_d = '0;
                xing_cnt_d = '0;
`ifdef BFSK_DEMOD_CARRIER_CHECK_EN
                if (w_xing_next == '0) begin
                    carrier_lost_d = 1'b1;
                    leave          = 1'b1;
                end else
`endif
                begin
                    data_out_d   = (w_xing_next >= c_xing_w'(XING_THRESH));
                    data_valid_d = 1'b1;
                    if (bit_cnt_q == c_bit_w'(FRAME_BITS - 1)) begin
                        frame_done_d = 1'b1;
                        leave        = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
        end

        if (leave) begin
            state_d     = ST_HUNT;
            sync_cnt_d  = '0;
            bit_cnt_d   = '0;
            prev_sign_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HUNT;
            sync_cnt_q   <= '0;
            samp_cnt_q   <= '0;
            xing_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            prev_sign_q  <= 1'b0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            xing_cnt_q   <= xing_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            prev_sign_q  <= prev_sign_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef BFSK_DEMOD_CARRIER_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            carrier_lost_q <= 1'b0;
        end else begin
            carrier_lost_q <= carrier_lost_d;
        end
    end
    assign carrier_lost = carrier_lost_q;
`else
    assign carrier_lost = 1'b0;
`endif

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_done = frame_done_q;
    assign locked     = (state_q != ST_HUNT);

endmodule
`default_nettype wire

// File: tb/tb_bfsk_demodulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bfsk_demodulator
// Description : Directed self-checking bench for bfsk_demodulator. A stream
//               model derives each expected bit from the crossing count of
//               the samples it sends; one compare process checks every strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bfsk_demodulator;

    localparam logic [17:0] c_sync = 18'h0FFFF;
    localparam logic [7:0]  c_bits = 8'b10110010;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [17:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        data_out, data_valid, locked, frame_done, carrier_lost;

    int checks = 0;
    int failures = 0;
    int dv_cnt = 0, fd_cnt = 0, cl_cnt = 0;

    typedef struct packed {
        logic carrier;
        logic bit_v;
        logic last;
    } exp_t;
    exp_t exp_q[$];

    bfsk_demodulator dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .locked       (locked),
        .frame_done   (frame_done),
        .carrier_lost (carrier_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Every-cycle comparison of outputs against the expectation queue.
    always @(negedge clk) begin
        if (!reset_n) begin
            checks++;
            if ({data_out, data_valid, locked, frame_done, carrier_lost} !== 5'b0) begin
                failures++;
                $display("FAIL reset_outputs actual=%b required=00000",
                         {data_out, data_valid, locked, frame_done, carrier_lost});
            end
        end else if (data_valid || frame_done || carrier_lost) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe dv=%b fd=%b cl=%b required=none",
                         data_valid, frame_done, carrier_lost);
            end else begin
                e = exp_q.pop_front();
                if (data_valid !== !e.carrier || carrier_lost !== e.carrier ||
                    frame_done !== e.last || (!e.carrier && data_out !== e.bit_v)) begin
                    failures++;
                    $display("FAIL strobe dv/out/fd/cl actual=%b%b%b%b required=%b%b%b%b",
                             data_valid, data_out, frame_done, carrier_lost,
                             !e.carrier, e.bit_v, e.last, e.carrier);
                end
            end
            if (data_valid)   dv_cnt++;
            if (frame_done)   fd_cnt++;
            if (carrier_lost) cl_cnt++;
        end
    end

    function automatic int sine(input int ph);
        real r;
        r = 16383.0 * $sin(2.0 * 3.14159265358979 * real'(ph) / 65536.0);
        return $rtoi(r);
    endfunction

    // One accepted sample; with gaps, random invalid cycles carrying junk first.
    task automatic put(input logic [17:0] s, input bit gaps);
        int n = 0;
        while (gaps && n < 10 && $urandom_range(0, 99) < 30) begin
            sample_in    = 18'($urandom);
            sample_valid = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        sample_in    = s;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_pre(input int n, input bit gaps);
        for (int i = 0; i < n; i++) put(c_sync, gaps);
    endtask

    // Sends a frame body of continuous-phase sine. Symbol cl_sym (if >=0) is a
    // constant 100. Stops early before sample stop_samp of symbol stop_sym.
    // The model counts neg->non-neg transitions per 400-sample window.
    task automatic send_body(input logic [7:0] bits, input bit gaps, input int cl_sym,
                             input int stop_sym, input int stop_samp,
                             output logic [7:0] model_bits);
        int ph = 0;
        int prev_s = 0;
        int s;
        int cnt;
        bit aborted = 0;
        model_bits = '0;
        for (int k = 0; k < 8; k++) begin
            cnt = 0;
            for (int j = 0; j < 400; j++) begin
                if (k == stop_sym && j == stop_samp) return;
                if (k == cl_sym) begin
                    s = 100;
                end else begin
                    s  = sine(ph);
                    ph = (ph + (bits[7-k] ? 1311 : 655)) & 16'hFFFF;
                end
                if (prev_s < 0 && s >= 0) cnt++;
                prev_s = s;
                if (j == 399 && !aborted) begin
`ifdef BFSK_DEMOD_CARRIER_CHECK_EN
                    if (cnt == 0) begin
                        exp_q.push_back('{carrier: 1'b1, bit_v: 1'b0, last: 1'b0});
                        aborted = 1;
                    end else
`endif
                    begin
                        model_bits[7-k] = (cnt >= 6);
                        exp_q.push_back('{carrier: 1'b0, bit_v: (cnt >= 6), last: (k == 7)});
                    end
                end
                put(18'(s), gaps);
            end
        end
    endtask

    task automatic run_frame(input bit gaps, input string tag);
        logic [7:0] mb;
        int dv0 = dv_cnt, fd0 = fd_cnt;
        send_pre(11, gaps);
        check({tag, "_locked_after_preamble"}, int'(locked), 1);
        send_body(c_bits, gaps, -1, -1, -1, mb);
        check({tag, "_model_bits"}, int'(mb), int'(c_bits));
        idle(3);
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_strobes"}, dv_cnt - dv0, 8);
        check({tag, "_frame_done"}, fd_cnt - fd0, 1);
        check({tag, "_locked_after_frame"}, int'(locked), 0);
    endtask

    initial begin
        logic [7:0] mb;
        int dv0, fd0, cl0;

        // Reset with random samples on the bus.
        #2 reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_in    = 18'($urandom);
            sample_valid = 1'($urandom);
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        sample_valid = 1'b0;
        idle(1);

        // One short of the preamble threshold must not lock.
        send_pre(7, 0);
        put(18'(sine(655 * 10)), 0);
        idle(2);
        check("short_preamble_locked", int'(locked), 0);

        // Exactly SYNC_MIN sync samples locks the cycle after the last one.
        send_pre(8, 0);
        check("min_preamble_locked", int'(locked), 1);
        send_body(c_bits, 0, -1, -1, -1, mb);
        idle(3);
        check("min_frame_drain", exp_q.size(), 0);

        run_frame(0, "single");
        run_frame(1, "gapped");

        // Back-to-back frames with no idle between them.
        dv0 = dv_cnt; fd0 = fd_cnt;
        send_pre(11, 0);
        send_body(c_bits, 0, -1, -1, -1, mb);
        send_pre(11, 0);
        check("b2b_relock", int'(locked), 1);
        send_body(c_bits, 0, -1, -1, -1, mb);
        idle(3);
        check("b2b_drain", exp_q.size(), 0);
        check("b2b_strobes", dv_cnt - dv0, 16);
        check("b2b_frame_done", fd_cnt - fd0, 2);

        // Reset at sample 200 of symbol 3.
        dv0 = dv_cnt;
        send_pre(11, 0);
        send_body(c_bits, 0, -1, 3, 200, mb);
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(3);
        check("midreset_strobes", dv_cnt - dv0, 3);
        check("midreset_drain", exp_q.size(), 0);
        run_frame(0, "after_reset");

        // Constant level for the whole of symbol 2.
        dv0 = dv_cnt; fd0 = fd_cnt; cl0 = cl_cnt;
        send_pre(11, 0);
        send_body(c_bits, 0, 2, -1, -1, mb);
        idle(3);
        check("carrier_drain", exp_q.size(), 0);
        check("carrier_locked", int'(locked), 0);
`ifdef BFSK_DEMOD_CARRIER_CHECK_EN
        check("carrier_strobes", dv_cnt - dv0, 2);
        check("carrier_frame_done", fd_cnt - fd0, 0);
        check("carrier_lost_pulses", cl_cnt - cl0, 1);
`else
        check("carrier_strobes", dv_cnt - dv0, 8);
        check("carrier_frame_done", fd_cnt - fd0, 1);
        check("carrier_lost_pulses", cl_cnt - cl0, 0);
        check("carrier_model_bits", int'(mb), int'(8'b10010010));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
